// File: rtl/mult_rr_arbiter_pkg.sv
// Shared constants and the round-robin pick function for the multiplier arbiter.
package mult_rr_arbiter_pkg;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    // Upper bound on requesters the pick function can scan.
    localparam int MAX_REQ = 64;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First valid requester at or after ptr, wrapping modulo nreq.
    // The loop is fully unrolled; nreq is a constant at every call site.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int unsigned        ptr,
                                      input int unsigned        nreq);
        pick_t       r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            i = ptr + k;
            if (i >= nreq) i = i - nreq;
            if (k < nreq && !r.found) begin
                if (valid[IDX_W'(i)]) begin
                    r.found = 1'b1;
                    r.idx   = IDX_W'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter_multiplier.sv
// Combinational unsigned multiplier, full-width product (no truncation).
module multiplier
    import mult_rr_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] y_o
);

    assign y_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier among NREQ requesters,
// with a registered, ID-tagged response under consumer backpressure.
module mult_rr_arbiter
    import mult_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ID_W  = $clog2(NREQ),
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [OP_W*NREQ-1:0] req_a_i,
    input  logic [OP_W*NREQ-1:0] req_b_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [PROD_W-1:0]    rsp_y_o,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [CNT_W-1:0]     done_cnt_o
);

    logic                rsp_valid_q, rsp_valid_d;
    logic [PROD_W-1:0]   rsp_y_q, rsp_y_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;

    logic                load;
    logic                accept;
    pick_t               pick;
    logic [ID_W-1:0]     win_id;
    logic [MAX_REQ-1:0]  vld_pad;
    logic [OP_W-1:0]     a_sel, b_sel;
    logic [PROD_W-1:0]   prod;

    // Output register is free when empty or being drained this cycle.
    assign load    = !rsp_valid_q || rsp_ready_i;
    assign vld_pad = MAX_REQ'(req_valid_i);
    assign pick    = rr_pick(vld_pad, 32'(ptr_q), NREQ);
    assign win_id  = pick.idx[ID_W-1:0];
    assign accept  = pick.found && load;
    assign a_sel   = req_a_i[win_id*OP_W +: OP_W];
    assign b_sel   = req_b_i[win_id*OP_W +: OP_W];

    multiplier u_mul (
        .a_i (a_sel),
        .b_i (b_sel),
        .y_o (prod)
    );

    // One-hot grant to the winner; forced low while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if (rst_n && accept) req_ready_o[win_id] = 1'b1;
    end

    // Next state: capture on accept, empty on idle drain, hold under stall.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        done_cnt_d  = done_cnt_q;
        if (rsp_valid_q && rsp_ready_i) done_cnt_d = done_cnt_q + CNT_W'(1);
        if (load) begin
            if (accept) begin
                rsp_valid_d = 1'b1;
                rsp_y_d     = prod;
                rsp_id_d    = win_id;
                ptr_d       = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + ID_W'(1);
            end else begin
                rsp_valid_d = 1'b0;
            end
        end
    end

    // State registers; async reset discards any in-flight product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            ptr_q       <= '0;
            done_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_id_o    = rsp_id_q;
    assign done_cnt_o  = done_cnt_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed bench for mult_rr_arbiter: a behavioural model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_mult_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_y;
    logic [ID_W-1:0]   rsp_id;
    logic [CNT_W-1:0]  done_cnt;

    int tests = 0;
    int fails = 0;

    mult_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_y_o     (rsp_y),
        .rsp_id_o    (rsp_id),
        .done_cnt_o  (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid, m_y, m_id, m_ptr, m_done;

    function automatic int winner(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_valid = 0; m_y = 0; m_id = 0; m_ptr = 0; m_done = 0;
        end else begin
            bit ld;
            ld = (m_valid == 0) || rsp_ready;
            if (m_valid != 0 && rsp_ready) m_done = (m_done + 1) % 65536;
            if (ld) begin
                w = winner(m_ptr, req_valid);
                if (w >= 0) begin
                    m_y     = int'(req_a[4*w +: 4]) * int'(req_b[4*w +: 4]);
                    m_id    = w;
                    m_valid = 1;
                    m_ptr   = (w + 1) % NREQ;
                end else begin
                    m_valid = 0;
                end
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        int w, exp_rdy;
        if (!rst_n) begin
            check("rst_rsp_valid", int'(rsp_valid), 0);
            check("rst_req_ready", int'(req_ready), 0);
        end else begin
            exp_rdy = 0;
            w = winner(m_ptr, req_valid);
            if (w >= 0 && (m_valid == 0 || rsp_ready)) exp_rdy = 1 << w;
            check("m_req_ready", int'(req_ready), exp_rdy);
            check("m_rsp_valid", int'(rsp_valid), m_valid);
            check("m_rsp_y",     int'(rsp_y),     m_y);
            check("m_rsp_id",    int'(rsp_id),    m_id);
            check("m_done_cnt",  int'(done_cnt),  m_done);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input int a, input int b);
        req_valid[i]   = 1'b1;
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_y",     int'(rsp_y),     0);
        check("reset_done_cnt",  int'(done_cnt),  0);
        check("reset_req_ready", int'(req_ready), 0);
        after_edge();
        rst_n = 1'b1;
        after_edge();

        // Round robin: all valid, a=i+1, b=3
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("rr_rsp_id", int'(rsp_id), (k - 1) % 4);
                check("rr_rsp_y",  int'(rsp_y),  3 * ((k - 1) % 4 + 1));
            end
            check("rr_req_ready", int'(req_ready), 1 << (k % 4));
            after_edge();
            if (k == 4) req_valid = '0;
        end
        @(negedge clk);
        check("rr_last_id", int'(rsp_id), 0);
        check("rr_last_y",  int'(rsp_y),  3);
        after_edge();
        @(negedge clk);
        check("rr_done_cnt", int'(done_cnt), 5);
        after_edge();

        // Single request: requester 2, 15*15 (pointer is 1 here)
        set_req(2, 15, 15);
        @(negedge clk);
        check("single_req_ready", int'(req_ready), 4'b0100);
        after_edge();
        clr_req(2);
        @(negedge clk);
        check("single_rsp_valid", int'(rsp_valid), 1);
        check("single_rsp_y",     int'(rsp_y),     225);
        check("single_rsp_id",    int'(rsp_id),    2);
        after_edge();
        @(negedge clk);
        check("single_done_cnt",  int'(done_cnt),  6);
        check("single_idle",      int'(rsp_valid), 0);

        // Pointer wrap: only 3, then only 0
        after_edge();
        set_req(3, 2, 5);
        @(negedge clk);
        check("wrap_ready3", int'(req_ready), 4'b1000);
        after_edge();
        clr_req(3);
        set_req(0, 3, 4);
        @(negedge clk);
        check("wrap_ready0", int'(req_ready), 4'b0001);
        check("wrap_y3",     int'(rsp_y),     10);
        after_edge();
        clr_req(0);
        @(negedge clk);
        check("wrap_id0", int'(rsp_id), 0);
        check("wrap_y0",  int'(rsp_y),  12);

        // Backpressure: requester 1 with 7*9, requester 3 waiting
        after_edge();
        set_req(1, 7, 9);
        set_req(3, 1, 2);
        @(negedge clk);
        check("bp_grant1", int'(req_ready), 4'b0010);
        after_edge();
        clr_req(1);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", int'(rsp_valid), 1);
            check("bp_hold_y",     int'(rsp_y),     63);
            check("bp_hold_id",    int'(rsp_id),    1);
            check("bp_no_ready",   int'(req_ready), 0);
            after_edge();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant3", int'(req_ready), 4'b1000);
        after_edge();
        clr_req(3);
        @(negedge clk);
        check("bp_rsp_id3", int'(rsp_id), 3);
        check("bp_rsp_y3",  int'(rsp_y),  2);

        // Async reset between edges while a product is pending
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", int'(rsp_valid), 0);
        check("arst_done_cnt",  int'(done_cnt),  0);
        check("arst_req_ready", int'(req_ready), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        after_edge();
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 1);
        @(negedge clk);
        check("arst_first_grant", int'(req_ready), 4'b0001);
        after_edge();
        req_valid = '0;
        @(negedge clk);
        check("arst_first_id", int'(rsp_id), 0);
        check("arst_first_y",  int'(rsp_y),  1);
        repeat (3) after_edge();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
